// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between the multi-cycle CPU and the loader/debug port.
// Each access runs IDLE -> ISSUE -> (WAIT) -> DONE. The CPU has priority; a starvation counter bounds the loader's wait.
module mem_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_stall,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ldr_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

  state_t      state, state_d;
  logic        we_q, we_d, owner_d;
  logic        grant, ldr_win;
  logic [2:0]  wait_cnt;
  logic [3:0]  starve_cnt;
  logic        mem_en_d, mem_we_d, cpu_done_d, ldr_done_d;

  assign grant     = (state == IDLE) & (cpu_req | ldr_req);
  assign ldr_win   = ldr_req & (~cpu_req | (starve_cnt == 4'(STARVE_LIMIT)));
  assign cpu_stall = cpu_req & ~cpu_done;

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      we_q       <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      cpu_done   <= 1'b0;
      ldr_done   <= 1'b0;
      wait_cnt   <= '0;
      starve_cnt <= '0;
    end else begin
      state    <= state_d;
      owner    <= owner_d;
      we_q     <= we_d;
      mem_en   <= mem_en_d;
      mem_we   <= mem_we_d;
      cpu_done <= cpu_done_d;
      ldr_done <= ldr_done_d;
      if (state == ISSUE && !we_q)
        wait_cnt <= 3'(MEM_LAT - 1);
      else if (state == WAIT && wait_cnt != '0)
        wait_cnt <= wait_cnt - 3'd1;
      // Loader losses only count while it is actually asking; the count saturates.
      if (grant) begin
        if (ldr_win)
          starve_cnt <= '0;
        else if (ldr_req && starve_cnt != 4'(STARVE_LIMIT))
          starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (cpu_req | ldr_req) state_d = ISSUE;
      ISSUE:   state_d = we_q ? DONE : WAIT;
      WAIT:    if (wait_cnt == '0) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state so that they come straight out of flops.
  always_comb begin
    owner_d = owner;
    we_d    = we_q;
    if (grant) begin
      owner_d = ldr_win;
      we_d    = ldr_win ? ldr_we : cpu_we;
    end
    mem_en_d   = (state_d == ISSUE);
    mem_we_d   = (state_d == ISSUE) & we_d;
    cpu_done_d = (state_d == DONE) & ~owner_d;
    ldr_done_d = (state_d == DONE) & owner_d;
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      ldr_rdata <= '0;
    end else begin
      if (grant) begin
        mem_addr  <= ldr_win ? ldr_addr  : cpu_addr;
        mem_wdata <= ldr_win ? ldr_wdata : cpu_wdata;
      end
      if (state == WAIT && wait_cnt == '0) begin
        if (owner)
          ldr_rdata <= mem_rdata;
        else
          cpu_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (read latency 1, 3, 4) share one stimulus stream
// and are each compared every cycle with a transaction-level model, plus directed vectors and sequences.
module tb_mem_port_arbiter;

  logic        CLK;
  logic        Reset;
  logic        cpu_req, cpu_we, ldr_req, ldr_we;
  logic [15:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata, mem_rdata;

  logic [2:0]  cpu_done, cpu_stall, ldr_done, mem_en, mem_we, owner;
  logic [15:0] cpu_rdata [3];
  logic [15:0] ldr_rdata [3];
  logic [15:0] mem_addr  [3];
  logic [15:0] mem_wdata [3];

  int n_cmp = 0;
  int n_bad = 0;

  initial begin
    CLK = 1'b1;
    forever #5 CLK = ~CLK;
  end

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_port_arbiter #(
      .ADDR_W(16), .DATA_W(16),
      .MEM_LAT(g == 0 ? 1 : (g == 1 ? 3 : 4)),
      .STARVE_LIMIT(4)
    ) u_dut (
      .CLK(CLK), .Reset(Reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata[g]), .cpu_done(cpu_done[g]), .cpu_stall(cpu_stall[g]),
      .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
      .ldr_rdata(ldr_rdata[g]), .ldr_done(ldr_done[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata), .owner(owner[g])
    );
  end

  // Reference model: one in-flight transaction per instance, tracked by its cycle offset from ISSUE.
  bit          m_valid = 1'b0;
  bit          m_busy  [3];
  int          m_k     [3];
  bit          m_tow   [3];
  bit          m_twe   [3];
  bit          m_owner [3];
  int          m_starve[3];
  logic [15:0] m_addr  [3];
  logic [15:0] m_wdata [3];
  logic [15:0] m_crd   [3];
  logic [15:0] m_lrd   [3];

  function automatic int lat_of(int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 4);
  endfunction

  // Offset of the done cycle: writes finish right after ISSUE, reads after the latency.
  function automatic int done_k(int i);
    return m_twe[i] ? 1 : lat_of(i) + 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit lw;
    for (int i = 0; i < 3; i++) begin
      if (!Reset) begin
        m_busy[i] = 0; m_k[i] = 0; m_tow[i] = 0; m_twe[i] = 0; m_owner[i] = 0; m_starve[i] = 0;
        m_addr[i] = '0; m_wdata[i] = '0; m_crd[i] = '0; m_lrd[i] = '0;
      end else if (m_busy[i]) begin
        if (!m_twe[i] && m_k[i] == lat_of(i)) begin
          if (m_tow[i]) m_lrd[i] = mem_rdata;
          else          m_crd[i] = mem_rdata;
        end
        m_k[i]++;
        if (m_k[i] > done_k(i)) m_busy[i] = 0;
      end else if (cpu_req || ldr_req) begin
        lw = ldr_req && (!cpu_req || m_starve[i] == 4);
        m_busy[i] = 1; m_k[i] = 0; m_tow[i] = lw; m_owner[i] = lw;
        m_twe[i]   = lw ? ldr_we    : cpu_we;
        m_addr[i]  = lw ? ldr_addr  : cpu_addr;
        m_wdata[i] = lw ? ldr_wdata : cpu_wdata;
        if (lw) m_starve[i] = 0;
        else if (ldr_req && m_starve[i] < 4) m_starve[i]++;
      end
    end
    if (!Reset) m_valid = 1'b1;
  endtask

  task automatic model_check();
    bit iss, dn;
    string p;
    if (!m_valid) return;
    for (int i = 0; i < 3; i++) begin
      iss = m_busy[i] && m_k[i] == 0;
      dn  = m_busy[i] && m_k[i] == done_k(i);
      p   = $sformatf("L%0d", lat_of(i));
      chk({p, " mem_en"},    32'(mem_en[i]),    32'(iss));
      chk({p, " mem_we"},    32'(mem_we[i]),    32'(iss && m_twe[i]));
      chk({p, " mem_addr"},  32'(mem_addr[i]),  32'(m_addr[i]));
      chk({p, " mem_wdata"}, 32'(mem_wdata[i]), 32'(m_wdata[i]));
      chk({p, " cpu_done"},  32'(cpu_done[i]),  32'(dn && !m_tow[i]));
      chk({p, " ldr_done"},  32'(ldr_done[i]),  32'(dn && m_tow[i]));
      chk({p, " cpu_rdata"}, 32'(cpu_rdata[i]), 32'(m_crd[i]));
      chk({p, " ldr_rdata"}, 32'(ldr_rdata[i]), 32'(m_lrd[i]));
      chk({p, " owner"},     32'(owner[i]),     32'(m_owner[i]));
      chk({p, " cpu_stall"}, 32'(cpu_stall[i]), 32'(cpu_req && !(dn && !m_tow[i])));
    end
  endtask

  task automatic half();
    @(negedge CLK);
    model_check();
  endtask

  task automatic edge_();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic cycle();
    half();
    edge_();
  endtask

  task automatic go_idle(input int n);
    Reset = 1'b1; cpu_req = 1'b0; ldr_req = 1'b0;
    repeat (n) cycle();
  endtask

  typedef struct {
    logic rst_n, creq, cwe;  logic [15:0] caddr, cwdata;
    logic lreq, lwe;         logic [15:0] laddr, lwdata, mrd;
    logic en, we;            logic [15:0] addr, wdata;
    logic cdone;             logic [15:0] crd;
    logic ldone;             logic [15:0] lrd;
    logic own, stall;
  } vec_t;

  vec_t tbl [9];
  int   grants;

  initial begin
    // Reset with both requests up, CPU read of 0x0010 (0xBEEF), then loader write 0x1234 -> 0x00FF.
    tbl[0] = '{0,1,0,16'h0010,16'h5555, 1,1,16'h00FF,16'h1234,16'h0000, 0,0,16'h0000,16'h0000, 0,16'h0000, 0,16'h0000, 0,1};
    tbl[1] = '{1,1,0,16'h0010,16'h5555, 1,1,16'h00FF,16'h1234,16'h0000, 0,0,16'h0000,16'h0000, 0,16'h0000, 0,16'h0000, 0,1};
    tbl[2] = '{1,1,0,16'h0010,16'h5555, 0,1,16'h00FF,16'h1234,16'hBEEF, 1,0,16'h0010,16'h5555, 0,16'h0000, 0,16'h0000, 0,1};
    tbl[3] = '{1,1,0,16'h0010,16'h5555, 0,1,16'h00FF,16'h1234,16'hBEEF, 0,0,16'h0010,16'h5555, 0,16'h0000, 0,16'h0000, 0,1};
    tbl[4] = '{1,1,0,16'h0010,16'h5555, 0,1,16'h00FF,16'h1234,16'h1111, 0,0,16'h0010,16'h5555, 1,16'hBEEF, 0,16'h0000, 0,0};
    tbl[5] = '{1,0,0,16'h0010,16'h5555, 1,1,16'h00FF,16'h1234,16'h2222, 0,0,16'h0010,16'h5555, 0,16'hBEEF, 0,16'h0000, 0,0};
    tbl[6] = '{1,0,0,16'h0010,16'h5555, 1,1,16'h00FF,16'h1234,16'h7777, 1,1,16'h00FF,16'h1234, 0,16'hBEEF, 0,16'h0000, 1,0};
    tbl[7] = '{1,0,0,16'h0010,16'h5555, 1,1,16'h00FF,16'h1234,16'h7777, 0,0,16'h00FF,16'h1234, 0,16'hBEEF, 1,16'h0000, 1,0};
    tbl[8] = '{1,0,0,16'h0010,16'h5555, 0,1,16'h00FF,16'h1234,16'h7777, 0,0,16'h00FF,16'h1234, 0,16'hBEEF, 0,16'h0000, 1,0};

    Reset = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010; cpu_wdata = 16'h5555;
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 16'h00FF; ldr_wdata = 16'h1234; mem_rdata = '0;
    cycle();

    for (int r = 0; r < 9; r++) begin
      Reset = tbl[r].rst_n; cpu_req = tbl[r].creq; cpu_we = tbl[r].cwe;
      cpu_addr = tbl[r].caddr; cpu_wdata = tbl[r].cwdata;
      ldr_req = tbl[r].lreq; ldr_we = tbl[r].lwe; ldr_addr = tbl[r].laddr;
      ldr_wdata = tbl[r].lwdata; mem_rdata = tbl[r].mrd;
      half();
      chk($sformatf("tbl%0d mem_en", r),    32'(mem_en[0]),    32'(tbl[r].en));
      chk($sformatf("tbl%0d mem_we", r),    32'(mem_we[0]),    32'(tbl[r].we));
      chk($sformatf("tbl%0d mem_addr", r),  32'(mem_addr[0]),  32'(tbl[r].addr));
      chk($sformatf("tbl%0d mem_wdata", r), 32'(mem_wdata[0]), 32'(tbl[r].wdata));
      chk($sformatf("tbl%0d cpu_done", r),  32'(cpu_done[0]),  32'(tbl[r].cdone));
      chk($sformatf("tbl%0d cpu_rdata", r), 32'(cpu_rdata[0]), 32'(tbl[r].crd));
      chk($sformatf("tbl%0d ldr_done", r),  32'(ldr_done[0]),  32'(tbl[r].ldone));
      chk($sformatf("tbl%0d ldr_rdata", r), 32'(ldr_rdata[0]), 32'(tbl[r].lrd));
      chk($sformatf("tbl%0d owner", r),     32'(owner[0]),     32'(tbl[r].own));
      chk($sformatf("tbl%0d cpu_stall", r), 32'(cpu_stall[0]), 32'(tbl[r].stall));
      edge_();
    end

    // Starvation: CPU re-requests continuously while the loader waits; watch the latency-1 instance.
    go_idle(10);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0200;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 16'h0300;
    grants = 0;
    for (int c = 0; c < 80 && grants < 5; c++) begin
      mem_rdata = 16'(16'h3000 + c);
      half();
      if (mem_en[0]) begin
        grants++;
        chk($sformatf("starve grant%0d owner", grants), 32'(owner[0]), 32'(grants == 5));
        if (grants == 5)
          chk("starve_cnt after loader win", 32'(g_dut[0].u_dut.starve_cnt), 32'd0);
      end
      edge_();
    end
    chk("starve grants seen", 32'(grants), 32'd5);

    // Latency 4: done six cycles after the request, carrying the value driven in cycle 5.
    go_idle(12);
    for (int c = 0; c < 8; c++) begin
      cpu_req = (c <= 6); cpu_we = 1'b0; cpu_addr = 16'h0040;
      mem_rdata = 16'hD000 | 16'(c);
      half();
      chk($sformatf("lat4 cpu_done c%0d", c), 32'(cpu_done[2]), 32'(c == 6));
      if (c == 6) chk("lat4 cpu_rdata", 32'(cpu_rdata[2]), 32'h0000_D005);
      edge_();
    end

    // Latency 3: reset during WAIT aborts silently; a fresh read afterwards completes.
    go_idle(12);
    for (int c = 0; c < 16; c++) begin
      Reset = (c != 3);
      cpu_req = (c <= 2) || (c >= 9 && c <= 14); cpu_we = 1'b0;
      cpu_addr = (c < 9) ? 16'h0080 : 16'h0081;
      mem_rdata = 16'hE000 | 16'(c);
      half();
      if (c == 1) chk("lat3 issue mem_en", 32'(mem_en[1]), 32'd1);
      if (c == 4) chk("lat3 state after reset", 32'(g_dut[1].u_dut.state), 32'd0);
      if (c >= 4 && c <= 8) chk($sformatf("lat3 no done c%0d", c), 32'(cpu_done[1]), 32'd0);
      if (c == 14) begin
        chk("lat3 fresh read done", 32'(cpu_done[1]), 32'd1);
        chk("lat3 fresh read data", 32'(cpu_rdata[1]), 32'h0000_E00D);
      end
      edge_();
    end

    // Random traffic, including requests dropped mid-transaction and occasional resets.
    for (int c = 0; c < 600; c++) begin
      Reset     = ($urandom_range(0, 79) != 0);
      cpu_req   = ($urandom_range(0, 3) != 0);
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_addr  = 16'($urandom);
      cpu_wdata = 16'($urandom);
      ldr_req   = 1'($urandom_range(0, 1));
      ldr_we    = 1'($urandom_range(0, 1));
      ldr_addr  = 16'($urandom);
      ldr_wdata = 16'($urandom);
      mem_rdata = 16'($urandom);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences the processor's single memory port and shares it between two requesters: the multi-cycle CPU, through its memory-read/memory-write and IoD address path, and a loader/debug port used to preload programs and inspect memory. Each transaction is a four-state handshake (IDLE, ISSUE, WAIT, DONE) with a fixed memory read latency. The CPU normally has priority. A starvation counter guarantees the loader progress. `cpu_stall` lets the CPU state register hold while its access is pending.

## Interface
- `ADDR_W`, 16: address width.
- `DATA_W`, 16: data width.
- `MEM_LAT`, 1: cycles from the ISSUE cycle to valid `mem_rdata`. Legal range is 1..4.
- `STARVE_LIMIT`, 4: consecutive lost arbitrations after which the loader wins. Legal range is 1..15.

Ports:
- `CLK`  in  1  the single clock; everything is rising-edge triggered.
- `Reset`  in  1  synchronous, active-low reset.
- `cpu_req`  in  1  CPU request, level-held until `cpu_done`.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  ADDR_W  CPU address.
- `cpu_wdata`  in  DATA_W  CPU write data.
- `cpu_rdata`  out  DATA_W  read data, valid while `cpu_done` = 1.
- `cpu_done`  out  1  one-cycle completion pulse.
- `cpu_stall`  out  1  equals `cpu_req & ~cpu_done`.
- `ldr_req`, `ldr_we`, `ldr_addr`, `ldr_wdata`, `ldr_rdata`, `ldr_done`: same meanings as the CPU signals, for the loader.
- `mem_en`  out  1  memory strobe.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data.
- `owner`  out  1  0 = CPU, 1 = loader; holds the last granted requester.

## Operation

**State machine (registered state, 2 bits)**
- IDLE: arbitrate at the clock edge.
  - If either request is high, latch the winner's `we`, `addr` and `wdata` into the transaction registers, set `owner`, and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE: `mem_en` = 1 and `mem_we` = latched `we`; `mem_addr` and `mem_wdata` come from the latched registers.
  - Write: go to DONE.
  - Read: load the wait counter with `MEM_LAT`-1 and go to WAIT.
- WAIT: `mem_en` = 0.
  - When the counter = 0, capture `mem_rdata` into the owner's `rdata` register and go to DONE.
  - Otherwise decrement the counter.
- DONE: pulse the owner's `done` for exactly one cycle, then go to IDLE.

**Arbitration**
- The loader wins if `ldr_req` = 1 and either `cpu_req` = 0 or `starve_cnt` = `STARVE_LIMIT`. Otherwise the CPU wins.
- `starve_cnt` (4 bits):
  - increments, saturating at `STARVE_LIMIT`, on each IDLE arbitration the loader loses while `ldr_req` = 1;
  - clears when the loader is granted.

**Output hold rules**
- `mem_addr` and `mem_wdata` hold their latched values outside ISSUE.
- `cpu_rdata` and `ldr_rdata` hold their values until the next read by the same owner overwrites them.
- A write never modifies either `rdata` register.

**Boundary conditions**
- A requester drops `req` mid-transaction: the transaction still completes and `done` still pulses.
- A requester keeps `req` high in the cycle after DONE: this is a new request.
- Both requests rise in the same cycle: the CPU wins unless the starvation counter is saturated.
- Reset asserted mid-transaction: the transaction is aborted with no `done` pulse.

**Reset values** (`Reset` = 0 at a clock edge)
- State is IDLE.
- `mem_en`, `mem_we`, `cpu_done`, `ldr_done` and `owner` are 0.
- `mem_addr`, `mem_wdata`, `cpu_rdata` and `ldr_rdata` are 0.
- `starve_cnt` and the wait counter are 0.
- `cpu_stall` follows `cpu_req` combinationally, so it is 1 during reset if `cpu_req` = 1.

## Timing
- A request first sampled high at the edge ending cycle 0 puts the block in ISSUE for cycle 1.
- Write: `done` is high in cycle 2. Total latency is 2 cycles.
- Read: `mem_rdata` is sampled at the end of cycle 1+`MEM_LAT`, and `done` and `rdata` are valid in cycle 2+`MEM_LAT`.
- The next arbitration happens at the edge ending the cycle after DONE. There is no back-to-back issue, so port occupancy is 3 cycles per write and 3+`MEM_LAT` per read.
- `cpu_stall` is combinational. All other outputs are registered.

## Test plan
1. **Reset.** Hold `Reset` = 0 for 2 cycles with both requests high. Required: every output listed under reset values is 0; after release, the CPU is granted first.
2. **CPU read.** `MEM_LAT` = 1, CPU read at 0x0010 from a memory model returning 0xBEEF. Required: `mem_en` high only in cycle 1 with `mem_addr` = 0x0010; `cpu_done` = 1 and `cpu_rdata` = 0xBEEF in cycle 3; `cpu_stall` = 1 in cycles 0–2.
3. **Loader write.** Loader write of 0x1234 to 0x00FF. Required: `mem_en` = `mem_we` = 1 in cycle 1 with that address and data; `ldr_done` pulses in cycle 2; `ldr_rdata` is unchanged.
4. **Starvation.** `STARVE_LIMIT` = 4; CPU issues continuous back-to-back reads while `ldr_req` is held high. Required: the CPU wins 4 arbitrations, the loader wins the 5th, then `starve_cnt` = 0.
5. **Latency sweep.** `MEM_LAT` = 4, CPU read. Required: `cpu_done` in cycle 6, and the data captured is the value the model drives in cycle 5.
6. **Reset mid-read.** `MEM_LAT` = 3; drive `Reset` = 0 during WAIT. Required: no `done` pulse, state is IDLE, and a fresh read issued after release completes correctly.
